// File: rtl/bram_stream_reader_if.sv
// ============================================================================
//  Module   : bram_stream_reader_if
//  Purpose  : Command, BRAM read-port and output-stream bundle for the reader.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface bram_stream_reader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 13
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_addr;
    logic [LEN_WIDTH-1:0]  length;
    logic                  busy;
    logic                  done;

    logic                  bram_ce;
    logic                  bram_we;
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic [DATA_WIDTH-1:0] bram_qout;

    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;

    modport master (
        input  start, base_addr, length, bram_qout, m_ready,
        output busy, done, bram_ce, bram_we, bram_addr, m_data, m_valid, m_last
    );

    modport slave (
        output start, base_addr, length, bram_qout, m_ready,
        input  busy, done, bram_ce, bram_we, bram_addr, m_data, m_valid, m_last
    );
endinterface

`default_nettype wire

// File: rtl/bram_stream_reader.sv
// ============================================================================
//  Module   : bram_stream_reader
//  Purpose  : Reads a contiguous BRAM range and streams it out as valid/ready.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bram_stream_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 12,
    parameter int LEN_WIDTH  = 13
) (
    input  wire logic            clk,
    input  wire logic            rst,
    bram_stream_reader_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic [ADDR_WIDTH-1:0] r_base;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [LEN_WIDTH-1:0]  r_issue_cnt;
    logic [LEN_WIDTH-1:0]  r_beat_cnt;
    logic                  r_inflight;

    logic [DATA_WIDTH-1:0] r_fifo [2];
    logic                  r_rd_ptr;
    logic                  r_wr_ptr;
    logic [1:0]            r_count;

    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_issue;
    logic                  w_last_beat;

    assign w_accept    = bus.start && (r_state != S_RUN);
    assign w_pop       = bus.m_valid && bus.m_ready;
    assign w_push      = r_inflight;
    assign w_last_beat = (r_beat_cnt == (r_len - LEN_WIDTH'(1)));

    // Credit: buffered + in-flight words after this cycle's pop must stay below 2.
    assign w_issue = (r_state == S_RUN) && (r_issue_cnt < r_len) &&
                     (({1'b0, r_count} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

    assign bus.busy      = (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.bram_ce   = w_issue;
    assign bus.bram_we   = 1'b0;
    assign bus.bram_addr = r_base + r_issue_cnt[ADDR_WIDTH-1:0];
    assign bus.m_valid   = (r_count != 2'd0);
    assign bus.m_data    = r_fifo[r_rd_ptr];
    assign bus.m_last    = bus.m_valid && w_last_beat;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_state_next = (bus.length != '0) ? S_RUN : S_DONE;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_pop && w_last_beat) begin
                    w_state_next = S_DONE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_len       <= '0;
            r_issue_cnt <= '0;
            r_beat_cnt  <= '0;
            r_inflight  <= 1'b0;
            r_fifo[0]   <= '0;
            r_fifo[1]   <= '0;
            r_rd_ptr    <= 1'b0;
            r_wr_ptr    <= 1'b0;
            r_count     <= 2'd0;
        end else begin
            r_state    <= w_state_next;
            r_inflight <= w_issue;

            if (w_accept) begin
                r_base      <= bus.base_addr;
                r_len       <= bus.length;
                r_issue_cnt <= '0;
                r_beat_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
                end
                if (w_pop) begin
                    r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                end
            end

            // Word issued last cycle is on bram_qout now.
            if (w_push) begin
                r_fifo[r_wr_ptr] <= bus.bram_qout;
                r_wr_ptr         <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
// ============================================================================
//  Module   : tb_bram_stream_reader
//  Purpose  : Scoreboard bench for bram_stream_reader with a BRAM model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 12;
    localparam int LW = 13;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    bram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory holds mem[i] = i, so each expected word is its own address.
    logic [DW-1:0] mem [0:4095];
    always @(posedge clk) begin
        if (bus.bram_ce) bus.bram_qout <= mem[bus.bram_addr];
    end

    logic [DW:0] sb [$];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic push_xfer(input logic [AW-1:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            sb.push_back({(i == len - 1), {(DW-AW){1'b0}}, a});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string nm, input int bound, input logic [63:0] pat, input bit use_pat);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < bound; k++) begin
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            tick();
            if (use_pat) bus.m_ready = (k < 64) ? pat[k] : 1'b1;
        end
        chk({nm, "_done_seen"}, 32'(seen), 32'd1);
        chk({nm, "_drained"}, sb.size(), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stream rules.
    initial begin
        int          outstanding;
        bit          have_stall;
        logic [DW:0] e;
        logic [DW-1:0] prev_data;
        outstanding = 0;
        have_stall  = 1'b0;
        prev_data   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                outstanding = 0;
                have_stall  = 1'b0;
            end else begin
                if (have_stall) begin
                    chk("hold_valid", 32'(bus.m_valid), 32'd1);
                    chk("hold_data", bus.m_data, prev_data);
                end
                if (bus.m_valid && bus.m_ready) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_beat", bus.m_data, 32'hDEAD_BEEF);
                    end else begin
                        e = sb.pop_front();
                        chk("beat_data", bus.m_data, e[DW-1:0]);
                        chk("beat_last", 32'(bus.m_last), 32'(e[DW]));
                    end
                end
                outstanding = outstanding + int'(bus.bram_ce) - int'(bus.m_valid && bus.m_ready);
                if (bus.busy) chk("credit_le2", 32'(outstanding <= 2), 32'd1);
                have_stall = bus.m_valid && !bus.m_ready;
                prev_data  = bus.m_data;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0]    t1_busy, t1_ce, t1_valid, t1_done;
        logic [AW-1:0] t2_addr [4];
        int            k;

        for (int i = 0; i < 4096; i++) mem[i] = DW'(i);
        t1_busy  = 9'b001111110;
        t1_ce    = 9'b000011110;
        t1_valid = 9'b001111000;
        t1_done  = 9'b010000000;
        t2_addr  = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};

        rst = 1'b1;
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.length = '0;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_ce", 32'(bus.bram_ce), 0);
        chk("rst_we", 32'(bus.bram_we), 0);
        chk("rst_valid", 32'(bus.m_valid), 0);
        chk("rst_last", 32'(bus.m_last), 0);
        chk("rst_addr", 32'(bus.bram_addr), 0);
        chk("rst_data", bus.m_data, 0);
        tick();
        rst = 1'b0;
        tick();

        // 1: basic transfer, cycle-accurate latency and done timing.
        push_xfer(12'h010, 4);
        bus.start = 1'b1; bus.base_addr = 12'h010; bus.length = 13'd4;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            chk("t1_busy", 32'(bus.busy), 32'(t1_busy[c]));
            chk("t1_ce", 32'(bus.bram_ce), 32'(t1_ce[c]));
            chk("t1_valid", 32'(bus.m_valid), 32'(t1_valid[c]));
            chk("t1_done", 32'(bus.done), 32'(t1_done[c]));
            if (t1_ce[c]) chk("t1_addr", 32'(bus.bram_addr), 32'h010 + 32'(c - 1));
            tick();
            if (c == 0) bus.start = 1'b0;
        end
        chk("t1_drained", sb.size(), 0);

        // 2: address wrap at top of memory.
        push_xfer(12'hFFE, 4);
        bus.start = 1'b1; bus.base_addr = 12'hFFE; bus.length = 13'd4;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("t2_ce", 32'(bus.bram_ce), 1);
            chk("t2_addr", 32'(bus.bram_addr), 32'(t2_addr[c]));
            tick();
        end
        wait_done("t2", 30, '1, 1'b0);
        tick();

        // 3: backpressure with a 5-cycle stall.
        push_xfer(12'h123, 8);
        bus.start = 1'b1; bus.base_addr = 12'h123; bus.length = 13'd8;
        bus.m_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        wait_done("t3", 60, 64'hFFFF_FFFF_FFFF_C1A5, 1'b1);
        tick();
        bus.m_ready = 1'b1;

        // 4a: zero-length command.
        bus.start = 1'b1; bus.base_addr = 12'h055; bus.length = 13'd0;
        @(negedge clk);
        chk("t4_c0_ce", 32'(bus.bram_ce), 0);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t4_done", 32'(bus.done), 1);
        chk("t4_busy", 32'(bus.busy), 0);
        chk("t4_ce", 32'(bus.bram_ce), 0);
        tick();
        @(negedge clk);
        chk("t4_done_once", 32'(bus.done), 0);
        tick();

        // 4b: start while busy is ignored.
        push_xfer(12'h200, 6);
        bus.start = 1'b1; bus.base_addr = 12'h200; bus.length = 13'd6;
        bus.m_ready = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start = 1'b1; bus.base_addr = 12'h300; bus.length = 13'd2;
        tick();
        bus.start = 1'b0;
        tick();
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("t4_resume_ce", 32'(bus.bram_ce), 1);
        chk("t4_resume_addr", 32'(bus.bram_addr), 32'h202);
        wait_done("t4b", 40, '1, 1'b0);
        tick();

        // 5: reset mid-transfer with 3 of 6 beats remaining.
        push_xfer(12'h040, 6);
        bus.start = 1'b1; bus.base_addr = 12'h040; bus.length = 13'd6;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        rst = 1'b1;
        bus.m_ready = 1'b0;
        chk("t5_remaining", sb.size(), 3);
        sb.delete();
        tick();
        rst = 1'b0;
        bus.m_ready = 1'b1;
        @(negedge clk);
        chk("t5_valid", 32'(bus.m_valid), 0);
        chk("t5_busy", 32'(bus.busy), 0);
        chk("t5_done", 32'(bus.done), 0);
        tick();
        @(negedge clk);
        chk("t5_no_done", 32'(bus.done), 0);
        tick();
        push_xfer(12'h100, 2);
        bus.start = 1'b1; bus.base_addr = 12'h100; bus.length = 13'd2;
        tick();
        bus.start = 1'b0;
        wait_done("t5", 30, '1, 1'b0);
        tick();

        // 6: back-to-back, second command accepted in the DONE cycle.
        push_xfer(12'h020, 3);
        push_xfer(12'h0A0, 2);
        bus.start = 1'b1; bus.base_addr = 12'h020; bus.length = 13'd3;
        tick();
        bus.base_addr = 12'h0A0; bus.length = 13'd2;
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.done) break;
            tick();
        end
        chk("t6_first_done_cycle", 32'(k), 5);
        tick();
        bus.start = 1'b0;
        @(negedge clk);
        chk("t6_busy", 32'(bus.busy), 1);
        chk("t6_ce", 32'(bus.bram_ce), 1);
        chk("t6_addr", 32'(bus.bram_addr), 32'h0A0);
        wait_done("t6", 30, '1, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bram_stream_reader.md
Name: bram_stream_reader

Overview:
Read-side sequencer for the true dual-port BRAM used for the MNIST feature and weight buffers. On a start command it reads a contiguous address range through one BRAM port. It emits the words as a valid/ready stream toward the compute datapath and absorbs the BRAM's 1-cycle read latency under backpressure. The block drives only the read side of the port; the write-enable it presents is held at 0.

Parameters:
DATA_WIDTH, 32, BRAM word width and stream data width.
ADDR_WIDTH, 12, BRAM address width.
LEN_WIDTH, 13, width of the length field; allows lengths up to 4096.

Ports:
clk  in  1  single clock shared with the BRAM.
rst  in  1  synchronous, active-high reset.
start  in  1  command strobe; accepted only while busy=0.
base_addr  in  ADDR_WIDTH  first address to read; sampled when start is accepted.
length  in  LEN_WIDTH  number of words to read; sampled when start is accepted.
busy  out  1  a transfer is in progress.
done  out  1  one-cycle pulse when a transfer completes.
bram_ce  out  1  BRAM port clock enable; high only on read-issue cycles.
bram_we  out  1  BRAM port write enable; constant 0.
bram_addr  out  ADDR_WIDTH  BRAM port address.
bram_qout  in  DATA_WIDTH  BRAM port read data; valid 1 cycle after a read issue, and holds while bram_ce=0.
m_data  out  DATA_WIDTH  stream data.
m_valid  out  1  stream data valid.
m_ready  in  1  downstream ready.
m_last  out  1  marks the final beat of a transfer; qualified by m_valid.

Behaviour:
- Reset (synchronous, rst=1 at a clock edge): state IDLE; busy, done, bram_ce, m_valid and m_last = 0; bram_addr, m_data = 0.
  - The output buffer is emptied, the in-flight flag is cleared, and the issue and beat counters are zeroed.
  - Reset mid-transfer aborts the transfer immediately: no done pulse, and any buffered words are discarded.
- States:
  - IDLE: start=1 and length!=0 -> RUN. Latch base_addr and length; clear the issue counter (words read) and the beat counter (words emitted).
  - IDLE: start=1 and length=0 -> DONE. No BRAM access, busy stays 0.
  - RUN: move to DONE at the edge where the beat with m_last=1 handshakes.
  - DONE: pulse done=1 for one cycle, then return to IDLE.
- busy=1 exactly while in RUN. start while busy=1 is ignored. start is accepted during the DONE cycle (back-to-back transfers).
- Read issue:
  - bram_addr = (latched base + issue counter) mod 2^ADDR_WIDTH, so the address wraps from 2^ADDR_WIDTH-1 to 0.
  - bram_ce=1 in a RUN cycle iff issue counter < length and (buffer occupancy + in-flight - pop) < 2, where pop = m_valid & m_ready.
  - Each issue increments the issue counter and sets the in-flight flag for the next cycle.
- Capture: a word issued in cycle N is taken from bram_qout in cycle N+1 and written into the 2-entry output FIFO at the end of cycle N+1.
  - Its earliest appearance on m_valid/m_data is cycle N+2.
- Output stream:
  - m_data/m_valid come from the FIFO head, in order, with no duplicates and no drops.
  - m_valid, once high, must not drop and m_data must not change until m_ready=1.
  - m_last=1 on the beat whose beat counter equals length-1.
- Latency: start high in cycle 0 -> bram_ce=1 with addr=base in cycle 1 -> m_valid=1 in cycle 3.
- Throughput: 1 beat/cycle sustained while m_ready is held high.
- Simultaneous capture and pop in the same cycle keeps occupancy unchanged. The FIFO never overflows because of the issue credit rule.
- Length arithmetic: counters are LEN_WIDTH bits. length=4096 with ADDR_WIDTH=12 reads every address once, wrapping at most once.

Test Plan:
1. rst, then start with base=0x010, len=4, m_ready=1, BRAM preloaded with mem[i]=i -> data 0x10..0x13 on consecutive cycles; first m_valid in cycle 3; m_last on 0x13; done pulse 1 cycle after; busy high cycles 1..(last handshake).
2. base=0xFFE, len=4 -> bram_addr FFE, FFF, 000, 001; data in that order.
3. len=8, m_ready toggled pseudo-randomly (and held low for 5 cycles) -> all 8 words delivered in order with none lost or duplicated; m_data stable while m_valid & !m_ready; never more than 2 reads outstanding beyond the buffered words.
4. start with len=0 -> no bram_ce, busy stays 0, done pulses in cycle 1. start pulsed during an active transfer -> ignored, latched parameters unchanged.
5. rst asserted while 3 of 6 beats remain -> next cycle m_valid=0, busy=0, no done pulse. A new start (base=0x100, len=2) then completes normally.
6. Back-to-back: start held high during the DONE cycle with a new base/length -> the second transfer begins with no idle cycle beyond DONE.
